// File: rtl/xnor_lab_pkg.sv
// Shared definitions for the 3-input XNOR lab: FSM state encoding and
// reference truth tables for the exhaustive response checker.
package xnor_lab_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_e;

  // Bit i holds the expected output for input vector i (A is the MSB of i).
  localparam logic [7:0] XNOR3_TRUTH = 8'b0110_1001;
  localparam logic [7:0] XOR3_TRUTH  = 8'b1001_0110;

  localparam int unsigned SETTLE_W = 8;

endpackage

// File: rtl/xnor_response_checker_if.sv
// Handshake/result bundle between the response checker (master) and the
// unit under test plus its observer (slave).
interface xnor_response_checker_if #(
  parameter int N_IN = 3
);

  logic            start;
  logic [N_IN-1:0] vec;
  logic            f;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_idx;

  modport master (
    input  start,
    input  f,
    output vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_idx
  );

  modport slave (
    output start,
    output f,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_idx
  );

endinterface

// File: rtl/xnor_response_checker_settle_timer.sv
// Load/decrement settle counter; expired is high whenever the count sits at zero.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/xnor_response_checker.sv
// Exhaustive response checker: steps the unit through every input vector,
// samples its output after a settle interval and scores it against EXPECTED.
module xnor_response_checker
  import xnor_lab_pkg::*;
#(
  parameter int                     N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = XNOR3_TRUTH,
  parameter int                     SETTLE   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  xnor_response_checker_if.master bus
);

  localparam logic [N_IN-1:0]     VEC_LAST = '1;
  localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;

  logic            timer_load;
  logic            timer_expired;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (RELOAD),
    .expired  (timer_expired)
  );

  assign mismatch = bus.f ^ EXPECTED[vec_q];
  assign err_next = err_q + {{N_IN{1'b0}}, mismatch};

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    timer_load   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d      = APPLY;
          vec_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          timer_load   = 1'b1;
        end
      end

      APPLY: begin
        if (timer_expired) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        err_d = err_next;
        if (mismatch && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_idx_d   = vec_q;
        end
        // Verdict uses err_next so a mismatch on the last vector still counts.
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d    = APPLY;
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_xnor_response_checker.sv
// Scoreboard bench: each run pushes its hand-computed verdict, and a monitor
// pops and compares it when done rises.
module tb_xnor_response_checker;
  import xnor_lab_pkg::*;

  typedef struct {
    int err;
    int pass;
    int fv;
    int fi;
  } exp_t;

  logic clk;
  logic rst_n;
  int   mode;
  int   checks;
  int   errors;
  exp_t sb[$];

  xnor_response_checker_if #(.N_IN(3)) bus ();

  xnor_response_checker #(
    .N_IN     (3),
    .EXPECTED (XNOR3_TRUTH),
    .SETTLE   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit models: 0 correct XNOR, 1 inverted, 2 stuck-0 at 101, 3 wrong at 111.
  always_comb begin
    case (mode)
      0:       bus.f = ~(^bus.vec);
      1:       bus.f = ^bus.vec;
      2:       bus.f = (bus.vec == 3'd5) ? 1'b0 : ~(^bus.vec);
      default: bus.f = (bus.vec == 3'd7) ? 1'b1 : ~(^bus.vec);
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_vec"},        int'(bus.vec),        0);
    checkOutput({tag, "_busy"},       int'(bus.busy),       0);
    checkOutput({tag, "_done"},       int'(bus.done),       0);
    checkOutput({tag, "_pass"},       int'(bus.pass),       0);
    checkOutput({tag, "_err_count"},  int'(bus.err_count),  0);
    checkOutput({tag, "_fail_valid"}, int'(bus.fail_valid), 0);
    checkOutput({tag, "_fail_idx"},   int'(bus.fail_idx),   0);
    checkOutput({tag, "_state"},      int'(dut.state_q),    int'(IDLE));
  endtask

  task automatic applyStimulus(input int m, input int e_err, input int e_pass,
                               input int e_fv, input int e_fi, input bit poke);
    int n;
    bit poked;
    exp_t e;
    e.err  = e_err;
    e.pass = e_pass;
    e.fv   = e_fv;
    e.fi   = e_fi;
    mode = m;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("start_vec",  int'(bus.vec),  0);
    checkOutput("start_busy", int'(bus.busy), 1);
    checkOutput("start_done", int'(bus.done), 0);
    n = 0;
    poked = 1'b0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
      if (poke && !poked && bus.busy && bus.vec == 3'd3) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checkOutput("run_cycles", n, 40);
    checkOutput("final_vec",  int'(bus.vec),  7);
    checkOutput("final_busy", int'(bus.busy), 0);
  endtask

  // Monitor: scores a run on the rising edge of done.
  initial begin
    bit   done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && !done_prev) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("err_count",  int'(bus.err_count),  e.err);
          checkOutput("pass",       int'(bus.pass),       e.pass);
          checkOutput("fail_valid", int'(bus.fail_valid), e.fv);
          checkOutput("fail_idx",   int'(bus.fail_idx),   e.fi);
        end
      end
      done_prev = (bus.done === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    mode      = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    checkReset("reset");
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("idle_state", int'(dut.state_q), int'(IDLE));
    checkOutput("idle_busy",  int'(bus.busy),    0);

    applyStimulus(0, 0, 1, 0, 0, 1'b0);
    applyStimulus(1, 8, 0, 1, 0, 1'b0);
    applyStimulus(2, 1, 0, 1, 5, 1'b0);
    applyStimulus(3, 1, 0, 1, 7, 1'b0);
    applyStimulus(0, 0, 1, 0, 0, 1'b1);

    // Abort a run at vec 6 with the 101 mismatch already logged.
    mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.vec != 3'd6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reached_vec6", int'(bus.vec),        6);
    checkOutput("abort_err_count",    int'(bus.err_count),  1);
    checkOutput("abort_fail_valid",   int'(bus.fail_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkReset("abort");
    rst_n = 1'b1;

    applyStimulus(0, 0, 1, 0, 0, 1'b0);
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
